nn_argmax_classifier: RTL and testbench
=======================================

# nn_argmax_classifier

Output-side stage of the MNIST accelerator. Consumes the stream of signed 32-bit output-neuron scores produced by `nn_accelerator_top` (one score per beat, one frame per image), tracks the running maximum, and presents the winning digit class with its score through a valid/ready handshake. It also keeps a frame counter and flags malformed frames. It sits between the accelerator's `values` output and whatever reads results (UART/debug/LED logic).

## Interface
Parameters:
- `DATA_W`, 32: score width, two's-complement signed.
- `NUM_CLASSES`, 10: scores per frame.
- `IDX_W`, 4: class index width; must satisfy 2^IDX_W >= NUM_CLASSES.
- `CNT_W`, 16: frame counter width.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: score beat valid.
- `in_ready`, output, 1: block accepts a beat.
- `in_data`, input, DATA_W: signed score.
- `in_last`, input, 1: final beat of the frame.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes the result.
- `out_class`, output, IDX_W: index of the maximum score.
- `out_score`, output, DATA_W: the maximum score.
- `out_error`, output, 1: frame length was not NUM_CLASSES.
- `frame_count`, output, CNT_W: number of results consumed.

## Operation
- States: ACCUM and HOLD. Reset enters ACCUM.
- A beat is accepted when `in_valid && in_ready`. `in_ready` = 1 in ACCUM and 0 in HOLD.
- The per-frame beat index `idx` starts at 0.
- On the first accepted beat (idx == 0): `best_score` <= `in_data`, `best_idx` <= 0.
- On later beats with idx < NUM_CLASSES: update only if `in_data` > `best_score` as a signed compare. Ties keep the lower index.
- Beats with idx >= NUM_CLASSES are not compared. `idx` saturates at NUM_CLASSES, and the error flag is set.
- On an accepted beat with `in_last`:
  - The beat is first compared as above.
  - `err` <= (idx != NUM_CLASSES-1) OR the earlier overflow flag.
  - Go to HOLD. `idx` and the overflow flag clear.
- In HOLD: `out_valid` = 1. `out_class`, `out_score` and `out_error` are stable until `out_ready`.
- On `out_valid && out_ready`: `frame_count` += 1, wrapping at 2^CNT_W. Return to ACCUM.
- A single-beat frame (`in_last` on idx 0) yields class 0 with `out_error` = 1.
- An in-flight frame with no `in_last` never produces output. Recovery is by reset only.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_class` = 0, `out_score` = 0, `out_error` = 0, `frame_count` = 0. Internal `idx` = 0, `best_*` = 0.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Throughput: NUM_CLASSES accepted beats plus at least 1 HOLD cycle per frame.
  - With `out_ready` held at 1: 11 cycles per 10-score frame.
  - The first beat of the next frame is accepted the cycle after the output handshake.
- `in_valid` during HOLD is back-pressured (`in_ready` = 0). No beat is lost or consumed.
- `out_valid`, once high, stays high until the handshake, regardless of input activity.
- Reset assertion mid-frame or in HOLD clears all state immediately (asynchronous). The partial result is discarded.
- All outputs are registered. There is no combinational path from the inputs to `out_*`. `in_ready` is a decode of state only.

## Structure
- Shared package `nn_pkg`: `DATA_W`, `NUM_CLASSES`, `IDX_W` constants, and the state encoding (ACCUM = 0, HOLD = 1). These are shared with `nn_accelerator_top` and the benches.
- No sub-modules are required.
  - A natural split is `nn_argmax_core`: a combinational signed compare-and-select of (`best_score`, `best_idx`) vs (`in_data`, `idx`) returning the updated pair.
  - The FSM, counters and handshake stay in `nn_argmax_classifier`.

## Test plan
- **Basic frame.** Scores 0..9 = {5, −3, 12, 7, 12, 0, −100, 11, 2, 1}, `in_last` on beat 9, `out_ready` = 1.
  - Expect `out_valid` 1 cycle later, `out_class` = 2, `out_score` = 12, `out_error` = 0, `frame_count` = 1.
- **Negative-only and tie.** All scores −5 except index 6 = −1 → `out_class` = 6. All scores equal to 0x80000000 → `out_class` = 0, `out_score` = 0x80000000.
- **Back-pressure.** Hold `out_ready` = 0 for 20 cycles with `in_valid` = 1 and the next frame presented.
  - Expect `in_ready` = 0 and outputs frozen throughout.
  - On release: handshake, then the next frame's beat 0 is accepted the following cycle, and the second result is correct.
- **Length errors.**
  - `in_last` on beat 6 → `out_error` = 1, `out_class` is the max of beats 0..6.
  - 13-beat frame with max at beat 11 → `out_error` = 1, and beat 11 is ignored.
- **Reset mid-frame.** Drop `rst` low after 4 beats, release, then send a valid frame with max at index 8.
  - Expect no spurious `out_valid`, `out_class` = 8, `frame_count` = 1.
- **Counter wrap** (CNT_W = 4 override). Run 17 frames → `frame_count` = 1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the MNIST accelerator output path.
package nn_pkg;

  localparam int DATA_W      = 32;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  // Classifier FSM: ACCUM collects scores, HOLD presents the result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/nn_argmax_core.sv
// Combinational compare-and-select for the running argmax.
// A candidate replaces the current best only when strictly greater (signed),
// so ties keep the lower index. The first beat of a frame always loads.
module nn_argmax_core #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic signed [DATA_W-1:0] best_score,
  input  logic        [IDX_W-1:0]  best_idx,
  input  logic signed [DATA_W-1:0] cand_score,
  input  logic        [IDX_W-1:0]  cand_idx,
  input  logic                     first,
  output logic signed [DATA_W-1:0] next_score,
  output logic        [IDX_W-1:0]  next_idx
);

  // Select the winner of the current best vs the incoming candidate
  always_comb begin
    next_score = best_score;
    next_idx   = best_idx;
    if (first || (cand_score > best_score)) begin
      next_score = cand_score;
      next_idx   = cand_idx;
    end
  end

endmodule

// File: rtl/nn_argmax_classifier.sv
// Argmax stage: accumulates one frame of signed scores, then holds the
// winning class/score on a valid/ready output until consumed.
module nn_argmax_classifier
  import nn_pkg::*;
#(
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int IDX_W       = nn_pkg::IDX_W,
  parameter int CNT_W       = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [IDX_W-1:0]  out_class,
  output logic signed [DATA_W-1:0] out_score,
  output logic                     out_error,
  output logic        [CNT_W-1:0]  frame_count
);

  // Beat index must be able to hold NUM_CLASSES itself (saturation value).
  localparam int IW = $clog2(NUM_CLASSES + 1);
  localparam logic [IW-1:0] LIMIT    = IW'(NUM_CLASSES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);

  state_t state_reg;
  state_t state_next;

  logic        [IW-1:0]     idx_reg;
  logic signed [DATA_W-1:0] best_score_reg;
  logic        [IDX_W-1:0]  best_idx_reg;
  logic                     ovf_reg;
  logic                     err_reg;
  logic        [CNT_W-1:0]  frame_count_reg;

  logic signed [DATA_W-1:0] core_score;
  logic        [IDX_W-1:0]  core_idx;
  logic                     beat_acc;
  logic                     res_take;
  logic                     in_range;

  assign beat_acc = in_valid && in_ready;
  assign res_take = out_valid && out_ready;
  assign in_range = (idx_reg < LIMIT);

  nn_argmax_core #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_core (
    .best_score (best_score_reg),
    .best_idx   (best_idx_reg),
    .cand_score (in_data),
    .cand_idx   (IDX_W'(idx_reg)),
    .first      (idx_reg == '0),
    .next_score (core_score),
    .next_idx   (core_idx)
  );

  // State register
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: leave ACCUM on the last beat, leave HOLD on the handshake
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (beat_acc && in_last) state_next = HOLD;
      HOLD:    if (res_take)            state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Handshake outputs are pure decodes of the state register
  always_comb begin
    in_ready  = (state_reg == ACCUM);
    out_valid = (state_reg == HOLD);
  end

  // Datapath: running max, beat index, length-error tracking, frame counter
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      idx_reg         <= '0;
      best_score_reg  <= '0;
      best_idx_reg    <= '0;
      ovf_reg         <= 1'b0;
      err_reg         <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      if (beat_acc) begin
        if (in_range) begin
          best_score_reg <= core_score;
          best_idx_reg   <= core_idx;
        end
        if (in_last) begin
          err_reg <= (idx_reg != LAST_IDX) || ovf_reg;
          idx_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (in_range) begin
          idx_reg <= idx_reg + IW'(1);
        end else begin
          // Extra beat beyond NUM_CLASSES: index stays saturated
          ovf_reg <= 1'b1;
        end
      end
      if (res_take) begin
        frame_count_reg <= frame_count_reg + CNT_W'(1);
      end
    end
  end

  assign out_class   = best_idx_reg;
  assign out_score   = best_score_reg;
  assign out_error   = err_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Directed bench for nn_argmax_classifier: table of frames plus hand-written
// back-pressure, reset-mid-frame and counter-wrap sequences.
module tb_nn_argmax_classifier;

  logic        clock;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready,  in_ready_w;
  logic        out_valid, out_valid_w;
  logic [3:0]  out_class, out_class_w;
  logic [31:0] out_score, out_score_w;
  logic        out_error, out_error_w;
  logic [15:0] frame_count;
  logic [3:0]  frame_count_w;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  nn_argmax_classifier dut (
    .clock       (clock),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
    .out_score   (out_score),
    .out_error   (out_error),
    .frame_count (frame_count)
  );

  // Narrow-counter copy sharing the same stimulus, for the wrap check
  nn_argmax_classifier #(.CNT_W(4)) dut_w (
    .clock       (clock),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready_w),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid_w),
    .out_ready   (out_ready),
    .out_class   (out_class_w),
    .out_score   (out_score_w),
    .out_error   (out_error_w),
    .frame_count (frame_count_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] s [13];
    int          len;
    int          exp_class;
    logic [31:0] exp_score;
    logic        exp_err;
  } vec_t;

  localparam int NV = 8;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted
  task automatic send_beat(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int vi);
    for (int b = 0; b < vec[vi].len; b++)
      send_beat(vec[vi].s[b], b == vec[vi].len - 1);
  endtask

  // Called at the negedge right after the last beat was accepted
  task automatic wait_result(input string tag, input int ec, input logic [31:0] es, input logic ee);
    chk({tag, ".latency"}, 64'(out_valid), 64'd1);
    for (int g = 0; g < 50 && !out_valid; g++) @(negedge clock);
    chk({tag, ".class"}, 64'(out_class), 64'(ec));
    chk({tag, ".score"}, 64'(out_score), 64'(es));
    chk({tag, ".error"}, 64'(out_error), 64'(ee));
    @(negedge clock);
    exp_count++;
    chk({tag, ".count"},   64'(frame_count),   64'(exp_count));
    chk({tag, ".count_w"}, 64'(frame_count_w), 64'(exp_count % 16));
    chk({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    $display("frame %s: class=%0d score=%0h err=%0b count=%0d", tag, out_class, out_score, out_error, frame_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{s: '{5, -3, 12, 7, 12, 0, -100, 11, 2, 1, 0, 0, 0},
               len: 10, exp_class: 2, exp_score: 32'd12, exp_err: 1'b0};
    vec[1] = '{s: '{-5, -5, -5, -5, -5, -5, -1, -5, -5, -5, 0, 0, 0},
               len: 10, exp_class: 6, exp_score: 32'hFFFF_FFFF, exp_err: 1'b0};
    vec[2] = '{s: '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                    32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                    32'h8000_0000, 32'h8000_0000, 0, 0, 0},
               len: 10, exp_class: 0, exp_score: 32'h8000_0000, exp_err: 1'b0};
    vec[3] = '{s: '{3, 9, -2, 9, 4, 8, 1, 0, 0, 0, 0, 0, 0},
               len: 7, exp_class: 1, exp_score: 32'd9, exp_err: 1'b1};
    vec[4] = '{s: '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 100, 0},
               len: 13, exp_class: 9, exp_score: 32'd10, exp_err: 1'b1};
    vec[5] = '{s: '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
               len: 1, exp_class: 0, exp_score: 32'd42, exp_err: 1'b1};
    vec[6] = '{s: '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 50, 0, 0, 0},
               len: 10, exp_class: 9, exp_score: 32'd50, exp_err: 1'b0};
    vec[7] = '{s: '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 0, 0, 0},
               len: 10, exp_class: 0, exp_score: 32'd4, exp_err: 1'b0};

    // Reset values
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rst.in_ready",  64'(in_ready),    64'd1);
    chk("rst.out_valid", 64'(out_valid),   64'd0);
    chk("rst.class",     64'(out_class),   64'd0);
    chk("rst.score",     64'(out_score),   64'd0);
    chk("rst.error",     64'(out_error),   64'd0);
    chk("rst.count",     64'(frame_count), 64'd0);
    chk("rst.count_w",   64'(frame_count_w), 64'd0);
    rst = 1'b1;
    @(negedge clock);

    // Reset mid-frame: 4 beats of a large score, then asynchronous reset
    for (int b = 0; b < 4; b++) send_beat(32'd1000 + 32'(b), 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.in_ready",  64'(in_ready),  64'd1);
    chk("midrst.score",     64'(out_score), 64'd0);
    @(negedge clock);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("midrst.no_spurious", 64'(out_valid), 64'd0);
    end
    for (int b = 0; b < 10; b++) send_beat((b == 8) ? 32'd99 : 32'(b), b == 9);
    wait_result("midrst", 8, 32'd99, 1'b0);

    // Table-driven frames, back to back
    for (int v = 0; v < NV; v++) begin
      send_frame(v);
      wait_result($sformatf("vec%0d", v), vec[v].exp_class, vec[v].exp_score, vec[v].exp_err);
    end

    // Back-pressure: result held while the next frame's beat 0 waits
    out_ready = 1'b0;
    send_frame(0);
    in_valid = 1'b1; in_data = 32'd77; in_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("bp.in_ready",  64'(in_ready),  64'd0);
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.class",     64'(out_class), 64'd2);
      chk("bp.score",     64'(out_score), 64'd12);
    end
    out_ready = 1'b1;
    @(negedge clock);
    exp_count++;
    chk("bp.release_ready", 64'(in_ready),    64'd1);
    chk("bp.release_valid", 64'(out_valid),   64'd0);
    chk("bp.release_count", 64'(frame_count), 64'(exp_count));
    $display("frame bp1: released, count=%0d", frame_count);
    @(negedge clock);  // beat 0 (77) accepted here
    for (int b = 1; b < 10; b++)
      send_beat((b == 5) ? 32'd90 : ((b == 9) ? 32'hFFFF_FFFC : 32'd0), b == 9);
    wait_result("bp2", 5, 32'd90, 1'b0);

    // Second pass over the table carries the narrow counter through its wrap
    for (int v = 0; v < NV; v++) begin
      send_frame(v);
      wait_result($sformatf("wrap%0d", v), vec[v].exp_class, vec[v].exp_score, vec[v].exp_err);
    end
    chk("wrap.final_count_w", 64'(frame_count_w), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
